// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor, one lookahead group per stage
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int STAGES = WIDTH / GROUP;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              v_q, v_d;
    logic              en;
    logic [WIDTH-1:0]  b_eff;
    logic [GROUP+1:0]  r;

    // Returns {carry into group MSB, group carry-out, group sum}; every carry is a flat sum of products.
    function automatic logic [GROUP+1:0] cla_group(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             cin
    );
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             t;
        logic             term;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            t = cin;
            for (int j = 0; j <= i; j++) begin
                t = t & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                t = t | term;
            end
            c[i+1] = t;
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    always_comb begin
        en      = !valid_q[STAGES-1] || out_ready;
        b_eff   = B ^ {WIDTH{sub}};
        valid_d = valid_q;
        carry_d = carry_q;
        v_d     = v_q;
        r       = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
        end
        if (en) begin
            valid_d[0] = in_valid;
            // Data registers only load behind a real beat, so bubbles leave the outputs untouched.
            if (in_valid) begin
                r                   = cla_group(A[GROUP-1:0], b_eff[GROUP-1:0], sub);
                a_d[0]              = A;
                b_d[0]              = b_eff;
                s_d[0]              = '0;
                s_d[0][GROUP-1:0]   = r[GROUP-1:0];
                carry_d[0]          = r[GROUP];
                if (STAGES == 1) begin
                    v_d = r[GROUP+1] ^ r[GROUP];
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    r = cla_group(a_q[k-1][k*GROUP +: GROUP], b_q[k-1][k*GROUP +: GROUP],
                                  carry_q[k-1]);
                    a_d[k]                   = a_q[k-1];
                    b_d[k]                   = b_q[k-1];
                    s_d[k]                   = s_q[k-1];
                    s_d[k][k*GROUP +: GROUP] = r[GROUP-1:0];
                    carry_d[k]               = r[GROUP];
                    if (k == STAGES - 1) begin
                        v_d = r[GROUP+1] ^ r[GROUP];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            v_q     <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            v_q     <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = valid_q[STAGES-1];
    assign S         = s_q[STAGES-1];
    assign Cout      = carry_q[STAGES-1];
    assign V         = v_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - directed and streaming bench for pipelined_cla_adder
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, sub16, cout16, v16;
    logic [15:0] a16, b16, s16;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, sub4, cout4, v4;
    logic [3:0]  a4, b4, s4;
    logic        in_valid32, in_ready32, out_valid32, out_ready32, sub32, cout32, v32;
    logic [31:0] a32, b32, s32;

    int checks = 0;
    int errors = 0;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .S(s16), .Cout(cout16), .V(v16)
    );

    pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
        .S(s4), .Cout(cout4), .V(v4)
    );

    pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .A(a32), .B(b32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
        .S(s32), .Cout(cout32), .V(v32)
    );

    // Reference: {V, Cout, S} for a width-bit add/sub, overflow from operand/result sign bits.
    function automatic logic [33:0] model(input int width, input logic [31:0] a,
                                          input logic [31:0] b, input logic sb);
        logic [31:0] mask, am, be, s;
        logic [32:0] sum;
        logic        c, v;
        mask = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        am   = a & mask;
        be   = (sb ? ~b : b) & mask;
        sum  = {1'b0, am} + {1'b0, be} + {32'd0, sb};
        s    = sum[31:0] & mask;
        c    = sum[width];
        v    = (am[width-1] == be[width-1]) && (s[width-1] != am[width-1]);
        return {v, c, s};
    endfunction

    task automatic drive(input int sel, input logic vld, input logic [31:0] a,
                         input logic [31:0] b, input logic sb);
        case (sel)
            0: begin in_valid16 = vld; a16 = a[15:0]; b16 = b[15:0]; sub16 = sb; end
            1: begin in_valid4 = vld; a4 = a[3:0]; b4 = b[3:0]; sub4 = sb; end
            default: begin in_valid32 = vld; a32 = a; b32 = b; sub32 = sb; end
        endcase
    endtask

    function automatic logic ov(input int sel);
        case (sel)
            0: return out_valid16;
            1: return out_valid4;
            default: return out_valid32;
        endcase
    endfunction

    function automatic logic rdy(input int sel);
        case (sel)
            0: return in_ready16;
            1: return in_ready4;
            default: return in_ready32;
        endcase
    endfunction

    function automatic logic [33:0] res(input int sel);
        case (sel)
            0: return {v16, cout16, 16'd0, s16};
            1: return {v4, cout4, 28'd0, s4};
            default: return {v32, cout32, s32};
        endcase
    endfunction

    // One isolated beat: measure latency in edges, then check S/Cout/V.
    task automatic run_beat(input int sel, input logic [31:0] a, input logic [31:0] b,
                            input logic sb, input logic [31:0] exp_s, input logic exp_c,
                            input logic exp_v, input int exp_lat, input string name);
        int          lat;
        logic [33:0] got;
        @(negedge clk);
        drive(sel, 1'b1, a, b, sb);
        #1;
        checks++;
        if (rdy(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b expected 1", name, rdy(sel));
        end
        @(negedge clk);
        drive(sel, 1'b0, 32'd0, 32'd0, 1'b0);
        lat = 1;
        while (!ov(sel) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = res(sel);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (got[31:0] !== exp_s) begin
            errors++;
            $display("FAIL %s_S: got %h expected %h", name, got[31:0], exp_s);
        end
        checks++;
        if (got[32] !== exp_c) begin
            errors++;
            $display("FAIL %s_Cout: got %b expected %b", name, got[32], exp_c);
        end
        checks++;
        if (got[33] !== exp_v) begin
            errors++;
            $display("FAIL %s_V: got %b expected %b", name, got[33], exp_v);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(2, 1'b0, 32'd0, 32'd0, 1'b0);
        out_ready16 = 1'b1;
        out_ready4  = 1'b1;
        out_ready32 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid16, out_valid4, out_valid32} !== 3'b000) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 000",
                     {out_valid16, out_valid4, out_valid32});
        end
        checks++;
        if ({s16, cout16, v16} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {s16, cout16, v16});
        end
        rst = 1'b0;
        out_ready16 = 1'b0;
        #1;
        checks++;
        if (in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready16);
        end
        out_ready16 = 1'b1;
    endtask

    task automatic test_add_sub16;
        run_beat(0, 32'h00FF, 32'h0001, 1'b0, 32'h0100, 1'b0, 1'b0, 4, "group_carry");
        run_beat(0, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 4, "full_wrap");
        run_beat(0, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, 4, "signed_ovf");
        run_beat(0, 32'h0005, 32'h0007, 1'b1, 32'hFFFE, 1'b0, 1'b0, 4, "sub_borrow");
        run_beat(0, 32'h8000, 32'h0001, 1'b1, 32'h7FFF, 1'b1, 1'b1, 4, "sub_no_borrow");
        run_beat(0, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, 1'b0, 4, "plain_add");
    endtask

    task automatic test_back_to_back;
        logic [33:0] expq[$];
        logic [33:0] e;
        logic [15:0] ra, rb, hs;
        logic        rs, hc, hv, exp_rdy, stall;
        int          sent, got;
        sent = 0;
        got  = 0;
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rs   = 1'($urandom_range(0, 1));
        hs   = '0;
        hc   = 1'b0;
        hv   = 1'b0;
        for (int c = 0; c < 200 && got < 20; c++) begin
            @(negedge clk);
            stall       = (c >= 8 && c < 11);
            out_ready16 = !stall;
            #1;
            exp_rdy = !out_valid16 || out_ready16;
            checks++;
            if (in_ready16 !== exp_rdy) begin
                errors++;
                $display("FAIL stream_in_ready c=%0d: got %b expected %b", c, in_ready16, exp_rdy);
            end
            if (stall) begin
                if (c == 8) begin
                    hs = s16;
                    hc = cout16;
                    hv = v16;
                end else begin
                    checks++;
                    if ({out_valid16, s16, cout16, v16} !== {1'b1, hs, hc, hv}) begin
                        errors++;
                        $display("FAIL stall_hold c=%0d: got %h expected %h", c,
                                 {out_valid16, s16, cout16, v16}, {1'b1, hs, hc, hv});
                    end
                end
            end
            if (out_valid16 && out_ready16) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra_beat: got S=%h expected no beat", s16);
                end else begin
                    e = expq.pop_front();
                    if ({v16, cout16, s16} !== {e[33], e[32], e[15:0]}) begin
                        errors++;
                        $display("FAIL stream_beat%0d: got V=%b C=%b S=%h expected V=%b C=%b S=%h",
                                 got, v16, cout16, s16, e[33], e[32], e[15:0]);
                    end
                end
                got++;
            end
            if (sent < 20) begin
                drive(0, 1'b1, {16'd0, ra}, {16'd0, rb}, rs);
                if (in_ready16) begin
                    expq.push_back(model(16, {16'd0, ra}, {16'd0, rb}, rs));
                    sent++;
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rs = 1'($urandom_range(0, 1));
                end
            end else begin
                drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
            end
        end
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        out_ready16 = 1'b1;
        checks++;
        if (got != 20) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 20", got);
        end
    endtask

    task automatic test_reset_midflight;
        int seen;
        out_ready16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 32'h1111 * (i + 1), 32'h0F0F, 1'b0);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid16) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midflight_out_valid: got %0d valid cycles expected 0", seen);
        end
        checks++;
        if ({s16, cout16, v16} !== 18'd0) begin
            errors++;
            $display("FAIL midflight_outputs: got %h expected 0", {s16, cout16, v16});
        end
    endtask

    task automatic test_width4;
        run_beat(1, 32'hF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1, "w4_wrap");
        run_beat(1, 32'h3, 32'h5, 1'b1, 32'hE, 1'b0, 1'b0, 1, "w4_sub");
        run_beat(1, 32'h7, 32'h1, 1'b0, 32'h8, 1'b0, 1'b1, 1, "w4_ovf");
    endtask

    task automatic test_width32;
        logic [31:0] ra, rb;
        logic        rs;
        logic [33:0] e;
        run_beat(2, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 4, "w32_carry");
        run_beat(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4, "w32_wrap");
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'(i % 2);
            e  = model(32, ra, rb, rs);
            run_beat(2, ra, rb, rs, e[31:0], e[32], e[33], 4, "w32_rand");
        end
    endtask

    initial begin
        test_reset;
        test_add_sub16;
        test_back_to_back;
        test_reset_midflight;
        test_width4;
        test_width32;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
